// File: rtl/pzbcm_credit_dispatcher.sv
// pzbcm_credit_dispatcher
// Credit-based round-robin dispatcher. One valid/ready input stream is routed,
// beat by beat, to one of ENTRIES destinations that are enabled and have at
// least one credit. The per-destination outputs are registered, with one cycle
// of latency and no backpressure. Consumers send credits back as they drain.
//
// Optional build macro: PZBCM_CREDIT_DISPATCHER_PACKET_LOCK_EN
//   Once a packet has started (a beat accepted with i_last=0), every later
//   beat goes to the same destination until the beat with i_last=1 arrives.
module pzbcm_credit_dispatcher #(
  parameter int WIDTH = 8,
  parameter type TYPE = logic [WIDTH-1:0],
  parameter int ENTRIES = 4,
  parameter int CREDITS = 2,
  parameter TYPE DEFAULT = TYPE'(0),
  localparam int CREDIT_WIDTH = $clog2(CREDITS + 1),
  localparam int INDEX_WIDTH = $clog2(ENTRIES)
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [ENTRIES-1:0]     i_enable,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  TYPE                    i_data,
  input  logic                   i_last,
  output logic [ENTRIES-1:0]     o_valid,
  output TYPE                    o_data [ENTRIES],
  output logic [INDEX_WIDTH-1:0] o_grant_index,
  input  logic [ENTRIES-1:0]     i_credit_return,
  output logic                   o_credit_error
);

  localparam int SUM_WIDTH = INDEX_WIDTH + 1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDITS);
  localparam logic [INDEX_WIDTH-1:0]  LAST_INDEX  = INDEX_WIDTH'(ENTRIES - 1);
  localparam logic [ENTRIES-1:0]      ONE_HOT_0   = {{(ENTRIES-1){1'b0}}, 1'b1};

  logic [CREDIT_WIDTH-1:0] credit_reg [ENTRIES];
  logic [INDEX_WIDTH-1:0]  ptr_reg;
  logic [INDEX_WIDTH-1:0]  ptr_next;
  logic [ENTRIES-1:0]      has_credit;
  logic [ENTRIES-1:0]      credit_full;
  logic [ENTRIES-1:0]      eligible;
  logic [ENTRIES-1:0]      dispatch;
  logic [ENTRIES-1:0]      overflow;
  logic [INDEX_WIDTH-1:0]  grant;
  logic                    transfer;

  logic [ENTRIES-1:0]      valid_reg;
  TYPE                     data_reg [ENTRIES];
  logic [INDEX_WIDTH-1:0]  grant_index_reg;
  logic                    credit_error_reg;

  // Per-destination status and the one-hot dispatch decision for this cycle.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    assign has_credit[gi]  = (credit_reg[gi] != '0);
    assign credit_full[gi] = (credit_reg[gi] == CREDIT_FULL);
    assign dispatch[gi]    = transfer && (grant == INDEX_WIDTH'(gi));
    // A return that finds the counter already full, with nothing leaving, is lost.
    assign overflow[gi]    = i_credit_return[gi] && !dispatch[gi] && credit_full[gi];
    assign o_data[gi]      = data_reg[gi];
  end

`ifdef PZBCM_CREDIT_DISPATCHER_PACKET_LOCK_EN
  logic                   lock_reg;
  logic [INDEX_WIDTH-1:0] lock_index_reg;

  // Eligibility: a locked packet may only continue to its own destination,
  // regardless of that destination's enable bit.
  always_comb begin
    eligible = i_enable & has_credit;
    if (lock_reg) begin
      eligible = has_credit & (ONE_HOT_0 << lock_index_reg);
    end
  end

  // Lock state: a non-final beat pins the destination, the final beat releases it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lock_reg       <= 1'b0;
      lock_index_reg <= '0;
    end else if (transfer) begin
      lock_reg       <= !i_last;
      lock_index_reg <= grant;
    end
  end
`else
  // Eligibility: enabled destinations that still hold a credit.
  always_comb begin
    eligible = i_enable & has_credit;
  end
`endif

  // Round-robin grant: the first eligible index at or above the pointer, wrapping.
  always_comb begin
    logic [SUM_WIDTH-1:0]   sum;
    logic [INDEX_WIDTH-1:0] cand;
    logic                   found;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      sum = {1'b0, ptr_reg} + SUM_WIDTH'(k);
      if (sum >= SUM_WIDTH'(ENTRIES)) begin
        sum = sum - SUM_WIDTH'(ENTRIES);
      end
      cand = sum[INDEX_WIDTH-1:0];
      if (!found && eligible[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // Ready depends only on registered state and i_enable, never on i_valid.
  assign o_ready  = |eligible;
  assign transfer = i_valid && o_ready;
  assign ptr_next = (grant == LAST_INDEX) ? '0 : grant + 1'b1;

  // Round-robin pointer moves past the winner on every accepted beat.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_reg <= '0;
    end else if (transfer) begin
      ptr_reg <= ptr_next;
    end
  end

  // Credit counters: -1 on dispatch, +1 on return, saturating at the full value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        credit_reg[i] <= CREDIT_FULL;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (dispatch[i] && !i_credit_return[i]) begin
          credit_reg[i] <= credit_reg[i] - 1'b1;
        end else if (!dispatch[i] && i_credit_return[i] && !credit_full[i]) begin
          credit_reg[i] <= credit_reg[i] + 1'b1;
        end
      end
    end
  end

  // Registered demux outputs: a single-cycle beat on the granted destination.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_reg       <= '0;
      grant_index_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        data_reg[i] <= DEFAULT;
      end
    end else begin
      valid_reg       <= dispatch;
      grant_index_reg <= transfer ? grant : '0;
      for (int i = 0; i < ENTRIES; i++) begin
        data_reg[i] <= dispatch[i] ? i_data : DEFAULT;
      end
    end
  end

  // Sticky credit overflow flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      credit_error_reg <= 1'b0;
    end else if (|overflow) begin
      credit_error_reg <= 1'b1;
    end
  end

  assign o_valid        = valid_reg;
  assign o_grant_index  = grant_index_reg;
  assign o_credit_error = credit_error_reg;

endmodule

// File: tb/tb_pzbcm_credit_dispatcher.sv
// Testbench for pzbcm_credit_dispatcher (ENTRIES=4, CREDITS=2, WIDTH=8).
// Each vector is one clock cycle: inputs are driven after the falling edge,
// o_ready is sampled before the rising edge, registered outputs 1 time unit after.
module tb_pzbcm_credit_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] enable;
  logic       valid_in;
  logic       ready;
  logic [7:0] data_in;
  logic       last;
  logic [3:0] valid_out;
  logic [7:0] data_out [4];
  logic [1:0] grant_index;
  logic [3:0] credit_return;
  logic       credit_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pzbcm_credit_dispatcher #(
    .WIDTH   (8),
    .ENTRIES (4),
    .CREDITS (2)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (enable),
    .i_valid         (valid_in),
    .o_ready         (ready),
    .i_data          (data_in),
    .i_last          (last),
    .o_valid         (valid_out),
    .o_data          (data_out),
    .o_grant_index   (grant_index),
    .i_credit_return (credit_return),
    .o_credit_error  (credit_error)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] en;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [3:0] ret;
    logic       chk_rdy;
    logic       exp_rdy;
    logic [3:0] exp_valid;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] en, logic v, logic [7:0] d, logic l,
                              logic [3:0] ret, logic cr, logic er, logic [3:0] ev,
                              logic [1:0] eg, logic [7:0] ed, logic ee);
    vec_t x;
    x.rst_n = r; x.en = en; x.valid = v; x.data = d; x.last = l; x.ret = ret;
    x.chk_rdy = cr; x.exp_rdy = er; x.exp_valid = ev; x.exp_grant = eg;
    x.exp_data = ed; x.exp_err = ee;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic rdy_seen;
    @(negedge clk);
    rst_n         = v.rst_n;
    enable        = v.en;
    valid_in      = v.valid;
    data_in       = v.data;
    last          = v.last;
    credit_return = v.ret;
    #1;
    rdy_seen = ready;
    if (v.chk_rdy) chk("ready", idx, 32'(ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk("o_valid", idx, 32'(valid_out), 32'(v.exp_valid));
    chk("grant_index", idx, 32'(grant_index), 32'(v.exp_grant));
    chk("credit_error", idx, 32'(credit_error), 32'(v.exp_err));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("o_data[%0d]", i), idx, 32'(data_out[i]),
          32'(v.exp_valid[i] ? v.exp_data : 8'h00));
    end
    $display("vec %0d: rst_n=%b en=%h valid=%b data=%h ret=%h ready=%b -> o_valid=%b grant=%0d err=%b",
             idx, v.rst_n, v.en, v.valid, v.data, v.ret, rdy_seen, valid_out, grant_index,
             credit_error);
  endtask

  initial begin
    rst_n = 1'b0; enable = 4'hF; valid_in = 1'b0; data_in = 8'h00;
    last = 1'b1; credit_return = 4'h0;

    // Reset held for two cycles.
    vecs.push_back(mk(0, 4'hF, 0, 8'h00, 1, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(0, 4'hF, 0, 8'h00, 1, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0));
    // Nine back-to-back beats, no returns: round-robin until credits run out.
    vecs.push_back(mk(1, 4'hF, 1, 8'h01, 1, 4'h0, 1, 1, 4'b0001, 0, 8'h01, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h02, 1, 4'h0, 1, 1, 4'b0010, 1, 8'h02, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h03, 1, 4'h0, 1, 1, 4'b0100, 2, 8'h03, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h04, 1, 4'h0, 1, 1, 4'b1000, 3, 8'h04, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h05, 1, 4'h0, 1, 1, 4'b0001, 0, 8'h05, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h06, 1, 4'h0, 1, 1, 4'b0010, 1, 8'h06, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h07, 1, 4'h0, 1, 1, 4'b0100, 2, 8'h07, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h08, 1, 4'h0, 1, 1, 4'b1000, 3, 8'h08, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h09, 1, 4'h0, 1, 0, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(1, 4'hF, 1, 8'h09, 1, 4'h0, 1, 0, 4'b0000, 0, 8'h00, 0));
    // Return all credits (two rounds).
    vecs.push_back(mk(1, 4'hF, 0, 8'h00, 1, 4'hF, 1, 0, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(1, 4'hF, 0, 8'h00, 1, 4'hF, 1, 1, 4'b0000, 0, 8'h00, 0));
    // Only 0 and 2 enabled, returning the previous beat's credit each cycle.
    vecs.push_back(mk(1, 4'h5, 1, 8'h10, 1, 4'h0, 1, 1, 4'b0001, 0, 8'h10, 0));
    vecs.push_back(mk(1, 4'h5, 1, 8'h11, 1, 4'h1, 1, 1, 4'b0100, 2, 8'h11, 0));
    vecs.push_back(mk(1, 4'h5, 1, 8'h12, 1, 4'h4, 1, 1, 4'b0001, 0, 8'h12, 0));
    vecs.push_back(mk(1, 4'h5, 1, 8'h13, 1, 4'h1, 1, 1, 4'b0100, 2, 8'h13, 0));
    vecs.push_back(mk(1, 4'h5, 0, 8'h00, 1, 4'h4, 1, 1, 4'b0000, 0, 8'h00, 0));
    // Destination 1: bring to credit 1, then dispatch+return in one cycle.
    vecs.push_back(mk(1, 4'h2, 1, 8'h20, 1, 4'h0, 1, 1, 4'b0010, 1, 8'h20, 0));
    vecs.push_back(mk(1, 4'h2, 1, 8'h21, 1, 4'h2, 1, 1, 4'b0010, 1, 8'h21, 0));
    // Two returns with no dispatch: the second overflows and sets the flag.
    vecs.push_back(mk(1, 4'h2, 0, 8'h00, 1, 4'h2, 1, 1, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(1, 4'h2, 0, 8'h00, 1, 4'h2, 1, 1, 4'b0000, 0, 8'h00, 1));
    // Flag stays set; counter saturated at 2, so exactly two beats fit.
    vecs.push_back(mk(1, 4'h2, 1, 8'h22, 1, 4'h0, 1, 1, 4'b0010, 1, 8'h22, 1));
    vecs.push_back(mk(1, 4'h2, 1, 8'h23, 1, 4'h0, 1, 1, 4'b0010, 1, 8'h23, 1));
    vecs.push_back(mk(1, 4'h2, 1, 8'h24, 1, 4'h0, 1, 0, 4'b0000, 0, 8'h00, 1));
    vecs.push_back(mk(1, 4'h2, 0, 8'h00, 1, 4'h2, 1, 0, 4'b0000, 0, 8'h00, 1));
    vecs.push_back(mk(1, 4'h2, 0, 8'h00, 1, 4'h2, 1, 1, 4'b0000, 0, 8'h00, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Reset one cycle after a handshake: beat dropped, credits and pointer restored.
    apply(mk(0, 4'hF, 0, 8'h00, 1, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0), 100);
    apply(mk(1, 4'hF, 1, 8'h30, 1, 4'h0, 1, 1, 4'b0001, 0, 8'h30, 0), 101);
    apply(mk(0, 4'hF, 1, 8'h31, 1, 4'h0, 1, 1, 4'b0000, 0, 8'h00, 0), 102);
    apply(mk(1, 4'h1, 1, 8'h32, 1, 4'h0, 1, 1, 4'b0001, 0, 8'h32, 0), 103);
    apply(mk(1, 4'h1, 1, 8'h33, 1, 4'h0, 1, 1, 4'b0001, 0, 8'h33, 0), 104);
    apply(mk(1, 4'h1, 1, 8'h34, 1, 4'h0, 1, 0, 4'b0000, 0, 8'h00, 0), 105);

`ifdef PZBCM_CREDIT_DISPATCHER_PACKET_LOCK_EN
    // Three-beat packet starting at pointer 1 stays on destination 1 while it
    // waits for a late credit, even though 2 and 3 have credit.
    apply(mk(0, 4'hF, 0, 8'h00, 1, 4'h0, 0, 0, 4'b0000, 0, 8'h00, 0), 200);
    apply(mk(1, 4'hF, 1, 8'h40, 1, 4'h0, 1, 1, 4'b0001, 0, 8'h40, 0), 201);
    apply(mk(1, 4'hF, 1, 8'h41, 0, 4'h1, 1, 1, 4'b0010, 1, 8'h41, 0), 202);
    apply(mk(1, 4'hF, 1, 8'h42, 0, 4'h0, 1, 1, 4'b0010, 1, 8'h42, 0), 203);
    apply(mk(1, 4'hF, 1, 8'h43, 1, 4'h0, 1, 0, 4'b0000, 0, 8'h00, 0), 204);
    apply(mk(1, 4'hF, 1, 8'h43, 1, 4'h0, 1, 0, 4'b0000, 0, 8'h00, 0), 205);
    apply(mk(1, 4'hF, 1, 8'h43, 1, 4'h2, 1, 0, 4'b0000, 0, 8'h00, 0), 206);
    apply(mk(1, 4'hF, 1, 8'h43, 1, 4'h0, 1, 1, 4'b0010, 1, 8'h43, 0), 207);
    apply(mk(1, 4'hF, 1, 8'h50, 1, 4'h0, 1, 1, 4'b0100, 2, 8'h50, 0), 208);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
